// File: rtl/otter_hazard_pkg.sv
// Shared types and constants for the OTTER hazard control unit.
package otter_hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } hc_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/forward_select.sv
// Operand forwarding select for a single EX-stage source register.
module forward_select
    import otter_hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_rs_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_regwrite_i,
    input  logic              mem_memread_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_regwrite_i,
    output logic [1:0]        fwd_o
);

    // EX/MEM ALU result wins over WB data; a load in MEM has no data yet
    always_comb begin
        fwd_o = FWD_RF;
        if (mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i) && !mem_memread_i) begin
            fwd_o = FWD_MEM;
        end else if (wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == ex_rs_i)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard control for the 5-stage OTTER pipeline: forwarding, load-use stalls,
// branch flushes, data-memory wait freeze and saturating perf counters.
module hazard_control_unit
    import otter_hazard_pkg::*;
#(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned LOAD_LAT     = 1,
    parameter int unsigned FLUSH_STAGES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [REG_AW-1:0] ID_RS1,
    input  logic [REG_AW-1:0] ID_RS2,
    input  logic              ID_USES_RS1,
    input  logic              ID_USES_RS2,
    input  logic [REG_AW-1:0] EX_RS1,
    input  logic [REG_AW-1:0] EX_RS2,
    input  logic [REG_AW-1:0] EX_RD,
    input  logic              EX_REGWRITE,
    input  logic              EX_MEMREAD2,
    input  logic [REG_AW-1:0] MEM_RD,
    input  logic              MEM_REGWRITE,
    input  logic              MEM_MEMREAD2,
    input  logic [REG_AW-1:0] WB_RD,
    input  logic              WB_REGWRITE,
    input  logic              BRANCH_TAKEN,
    input  logic              MEM_BUSY,
    output logic              PC_WRITE,
    output logic              FD_WRITE,
    output logic              DE_WRITE,
    output logic              EM_WRITE,
    output logic              FD_FLUSH,
    output logic              DE_FLUSH,
    output logic [1:0]        FWD_A,
    output logic [1:0]        FWD_B,
    output logic [1:0]        HC_STATE,
    output logic [CNT_W-1:0]  STALL_COUNT,
    output logic [CNT_W-1:0]  FLUSH_COUNT
);

    localparam int unsigned MAXC = (LOAD_LAT > FLUSH_STAGES) ? LOAD_LAT : FLUSH_STAGES;
    localparam int unsigned CW   = (MAXC < 2) ? 1 : $clog2(MAXC + 1);

    hc_state_t        state_q, state_d, saved_q, saved_d, eff_state;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic             pc_we, fd_we, de_we, em_we, fd_fl, de_fl, flush_evt, luh;
    logic [1:0]       fwd_a, fwd_b;

    forward_select #(.REG_AW(REG_AW)) u_fwd_a (
        .ex_rs_i        (EX_RS1),
        .mem_rd_i       (MEM_RD),
        .mem_regwrite_i (MEM_REGWRITE),
        .mem_memread_i  (MEM_MEMREAD2),
        .wb_rd_i        (WB_RD),
        .wb_regwrite_i  (WB_REGWRITE),
        .fwd_o          (fwd_a)
    );

    forward_select #(.REG_AW(REG_AW)) u_fwd_b (
        .ex_rs_i        (EX_RS2),
        .mem_rd_i       (MEM_RD),
        .mem_regwrite_i (MEM_REGWRITE),
        .mem_memread_i  (MEM_MEMREAD2),
        .wb_rd_i        (WB_RD),
        .wb_regwrite_i  (WB_REGWRITE),
        .fwd_o          (fwd_b)
    );

    assign luh = EX_MEMREAD2 && EX_REGWRITE && (EX_RD != '0) &&
                 ((ID_USES_RS1 && (ID_RS1 == EX_RD)) || (ID_USES_RS2 && (ID_RS2 == EX_RD)));

    // Leaving MEM_WAIT resumes the saved state in the same cycle, so the
    // saved state (with its untouched counter) is evaluated as if current.
    assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;

    // Next-state, control enables and counter updates
    always_comb begin
        pc_we     = 1'b1;
        fd_we     = 1'b1;
        de_we     = 1'b1;
        em_we     = 1'b1;
        fd_fl     = 1'b0;
        de_fl     = 1'b0;
        flush_evt = 1'b0;
        state_d   = eff_state;
        saved_d   = saved_q;
        cnt_d     = cnt_q;
        if (MEM_BUSY) begin
            pc_we   = 1'b0;
            fd_we   = 1'b0;
            de_we   = 1'b0;
            em_we   = 1'b0;
            state_d = MEM_WAIT;
            saved_d = eff_state;
        end else if (BRANCH_TAKEN) begin
            fd_fl     = 1'b1;
            de_fl     = 1'b1;
            flush_evt = 1'b1;
            if (FLUSH_STAGES > 1) begin
                state_d = FLUSH;
                cnt_d   = CW'(FLUSH_STAGES - 1);
            end else begin
                state_d = RUN;
            end
        end else begin
            case (eff_state)
                FLUSH: begin
                    fd_fl = 1'b1;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = RUN;
                end
                LOAD_STALL: begin
                    pc_we = 1'b0;
                    fd_we = 1'b0;
                    de_fl = 1'b1;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = RUN;
                end
                default: begin
                    if (luh) begin
                        pc_we = 1'b0;
                        fd_we = 1'b0;
                        de_fl = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = LOAD_STALL;
                            cnt_d   = CW'(LOAD_LAT - 1);
                        end
                    end
                end
            endcase
        end
        stall_d = stall_q;
        flush_d = flush_q;
        if (!pc_we && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
        if (flush_evt && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
    end

    // State, saved state, down-counter and perf counter registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= RUN;
            saved_q <= RUN;
            cnt_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign PC_WRITE    = RST & pc_we;
    assign FD_WRITE    = RST & fd_we;
    assign DE_WRITE    = RST & de_we;
    assign EM_WRITE    = RST & em_we;
    assign FD_FLUSH    = !RST | fd_fl;
    assign DE_FLUSH    = !RST | de_fl;
    assign FWD_A       = RST ? fwd_a : FWD_RF;
    assign FWD_B       = RST ? fwd_b : FWD_RF;
    assign HC_STATE    = state_q;
    assign STALL_COUNT = stall_q;
    assign FLUSH_COUNT = flush_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios plus random
// traffic checked against a cycle-level behavioural model.
module tb_hazard_control_unit;

    localparam int LL  = 3;
    localparam int FS  = 2;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_u1, id_u2, ex_rw, ex_mr, mem_rw, mem_mr, wb_rw, br, busy;
    logic pcw, fdw, dew, emw, fdfl, defl;
    logic [1:0] fa, fb, hc;
    logic [CW-1:0] scnt, fcnt;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int m_stall, m_flush, m_scnt, m_fcnt;
    bit m_wait;
    int e_pcw, e_fdw, e_dew, e_emw, e_fdfl, e_defl, e_fa, e_fb, e_hc, e_brk;

    hazard_control_unit #(.REG_AW(5), .LOAD_LAT(LL), .FLUSH_STAGES(FS), .CNT_W(CW)) dut (
        .CLK(clk), .RST(rst),
        .ID_RS1(id_rs1), .ID_RS2(id_rs2), .ID_USES_RS1(id_u1), .ID_USES_RS2(id_u2),
        .EX_RS1(ex_rs1), .EX_RS2(ex_rs2), .EX_RD(ex_rd),
        .EX_REGWRITE(ex_rw), .EX_MEMREAD2(ex_mr),
        .MEM_RD(mem_rd), .MEM_REGWRITE(mem_rw), .MEM_MEMREAD2(mem_mr),
        .WB_RD(wb_rd), .WB_REGWRITE(wb_rw),
        .BRANCH_TAKEN(br), .MEM_BUSY(busy),
        .PC_WRITE(pcw), .FD_WRITE(fdw), .DE_WRITE(dew), .EM_WRITE(emw),
        .FD_FLUSH(fdfl), .DE_FLUSH(defl), .FWD_A(fa), .FWD_B(fb),
        .HC_STATE(hc), .STALL_COUNT(scnt), .FLUSH_COUNT(fcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int mfwd(input logic [4:0] rs);
        if (mem_rw && mem_rd != 0 && mem_rd == rs && !mem_mr) return 1;
        if (wb_rw && wb_rd != 0 && wb_rd == rs) return 2;
        return 0;
    endfunction

    task automatic idle();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_u1, id_u2, ex_rw, ex_mr, mem_rw, mem_mr, wb_rw, br, busy} = '0;
    endtask

    // Expected outputs this cycle from the remaining-cycle bookkeeping
    task automatic model_eval();
        bit luh;
        if (!rst) begin
            m_stall = 0; m_flush = 0; m_wait = 0; m_scnt = 0; m_fcnt = 0;
            e_pcw = 0; e_fdw = 0; e_dew = 0; e_emw = 0;
            e_fdfl = 1; e_defl = 1; e_fa = 0; e_fb = 0; e_hc = 0; e_brk = 0;
        end else begin
            luh = ex_mr && ex_rw && ex_rd != 0 &&
                  ((id_u1 && id_rs1 == ex_rd) || (id_u2 && id_rs2 == ex_rd));
            e_fa = mfwd(ex_rs1);
            e_fb = mfwd(ex_rs2);
            e_hc = m_wait ? 3 : (m_stall > 0) ? 1 : (m_flush > 0) ? 2 : 0;
            e_pcw = 1; e_fdw = 1; e_dew = 1; e_emw = 1; e_fdfl = 0; e_defl = 0; e_brk = 0;
            if (busy) begin
                e_pcw = 0; e_fdw = 0; e_dew = 0; e_emw = 0;
            end else if (br) begin
                e_fdfl = 1; e_defl = 1; e_brk = 1;
                m_stall = 0;
                m_flush = FS - 1;
            end else if (m_flush > 0) begin
                e_fdfl = 1;
                m_flush--;
            end else if (m_stall > 0) begin
                e_pcw = 0; e_fdw = 0; e_defl = 1;
                m_stall--;
            end else if (luh) begin
                e_pcw = 0; e_fdw = 0; e_defl = 1;
                m_stall = LL - 1;
            end
        end
    endtask

    task automatic eval_check(input string tag);
        int h, s, f;
        #3;
        h = (!rst) ? 0 : (m_wait ? 3 : (m_stall > 0) ? 1 : (m_flush > 0) ? 2 : 0);
        s = rst ? m_scnt : 0;
        f = rst ? m_fcnt : 0;
        chk({tag, ".HC_STATE"}, hc, h);
        chk({tag, ".STALL_COUNT"}, scnt, s);
        chk({tag, ".FLUSH_COUNT"}, fcnt, f);
        model_eval();
        chk({tag, ".PC_WRITE"}, pcw, e_pcw);
        chk({tag, ".FD_WRITE"}, fdw, e_fdw);
        chk({tag, ".DE_WRITE"}, dew, e_dew);
        chk({tag, ".EM_WRITE"}, emw, e_emw);
        chk({tag, ".FD_FLUSH"}, fdfl, e_fdfl);
        chk({tag, ".DE_FLUSH"}, defl, e_defl);
        chk({tag, ".FWD_A"}, fa, e_fa);
        chk({tag, ".FWD_B"}, fb, e_fb);
    endtask

    // Commit counters and the wait flag, then move to the next cycle
    task automatic adv();
        if (rst) begin
            m_wait = busy;
            if (!e_pcw && m_scnt < SAT) m_scnt++;
            if (e_brk && m_fcnt < SAT) m_fcnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag);
        eval_check(tag);
        adv();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        step("rst");
        rst = 1'b1;
    endtask

    task automatic set_load_use();
        ex_mr = 1; ex_rw = 1; ex_rd = 5'd7; id_u2 = 1; id_rs2 = 5'd7;
    endtask

    initial begin
        m_stall = 0; m_flush = 0; m_wait = 0; m_scnt = 0; m_fcnt = 0;
        e_pcw = 0; e_brk = 0;
        rst = 1'b0;
        idle();
        eval_check("reset");
        chk("reset.PC_WRITE_low", pcw, 0);
        chk("reset.DE_FLUSH_high", defl, 1);
        adv();
        rst = 1'b1;

        // forwarding priority
        ex_rw = 1; ex_rd = 5'd5; ex_rs1 = 5'd5;
        mem_rd = 5'd5; mem_rw = 1; wb_rd = 5'd5; wb_rw = 1;
        eval_check("fwd_mem"); chk("fwd_mem.const", fa, 2'b01); adv();
        mem_rd = 5'd0;
        eval_check("fwd_wb"); chk("fwd_wb.const", fa, 2'b10); adv();
        ex_rs1 = 5'd0;
        eval_check("fwd_x0"); chk("fwd_x0.const", fa, 2'b00); adv();
        ex_rs1 = 5'd5; mem_rd = 5'd5; mem_mr = 1;
        eval_check("fwd_memload"); chk("fwd_memload.const", fa, 2'b10); adv();

        // load-use stall, LOAD_LAT=3
        do_reset();
        set_load_use();
        eval_check("lu0"); chk("lu0.PC", pcw, 0); chk("lu0.DE_FLUSH", defl, 1); adv();
        idle();
        for (int i = 1; i < 3; i++) begin
            eval_check("lu"); chk("lu.PC", pcw, 0); chk("lu.DE_FLUSH", defl, 1); adv();
        end
        eval_check("lu_end"); chk("lu_end.PC", pcw, 1); chk("lu_end.HC", hc, 0);
        chk("lu_end.STALL_COUNT", scnt, 3); adv();

        // branch flush, FLUSH_STAGES=2
        do_reset();
        br = 1;
        eval_check("br0"); chk("br0.FD", fdfl, 1); chk("br0.DE", defl, 1); adv();
        br = 0;
        eval_check("br1"); chk("br1.FD", fdfl, 1); chk("br1.DE", defl, 0); adv();
        eval_check("br2"); chk("br2.FD", fdfl, 0); chk("br2.DE", defl, 0);
        chk("br2.FLUSH_COUNT", fcnt, 1); adv();

        // load-use and branch in the same cycle
        do_reset();
        set_load_use(); br = 1;
        eval_check("lubr"); chk("lubr.PC", pcw, 1); chk("lubr.FD", fdfl, 1); adv();
        idle();
        step("lubr1");
        eval_check("lubr2"); chk("lubr2.STALL_COUNT", scnt, 0); adv();

        // memory wait during a load stall
        do_reset();
        set_load_use();
        step("mw0");
        idle(); busy = 1;
        for (int i = 0; i < 4; i++) begin
            eval_check("mw_busy");
            chk("mw_busy.PC", pcw, 0); chk("mw_busy.EM", emw, 0); chk("mw_busy.DE_FLUSH", defl, 0);
            adv();
        end
        busy = 0;
        eval_check("mw_res0"); chk("mw_res0.HC", hc, 3); chk("mw_res0.PC", pcw, 0); adv();
        eval_check("mw_res1"); chk("mw_res1.HC", hc, 1); chk("mw_res1.PC", pcw, 0); adv();
        eval_check("mw_end"); chk("mw_end.HC", hc, 0); chk("mw_end.PC", pcw, 1);
        chk("mw_end.STALL_COUNT", scnt, 7); adv();

        // asynchronous reset in the middle of a flush
        do_reset();
        br = 1;
        step("arst_br");
        br = 0;
        chk("arst_pre.HC", hc, 2);
        rst = 1'b0;
        #1;
        chk("arst.HC", hc, 0); chk("arst.PC", pcw, 0); chk("arst.FD", fdfl, 1);
        chk("arst.DE", defl, 1); chk("arst.FLUSH_COUNT", fcnt, 0);
        step("arst_hold");
        rst = 1'b1;
        eval_check("arst_rel"); chk("arst_rel.HC", hc, 0); chk("arst_rel.FLUSH_COUNT", fcnt, 0); adv();

        // random traffic, long enough for both counters to saturate
        do_reset();
        for (int i = 0; i < 800; i++) begin
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
            wb_rd  = 5'($urandom_range(0, 3));
            id_u1 = 1'($urandom); id_u2 = 1'($urandom);
            ex_rw = 1'($urandom); ex_mr = 1'($urandom);
            mem_rw = 1'($urandom); mem_mr = 1'($urandom); wb_rw = 1'($urandom);
            br   = ($urandom_range(0, 7) == 0);
            busy = ($urandom_range(0, 5) == 0);
            step("rand");
        end
        idle();
        eval_check("sat"); chk("sat.STALL_COUNT", scnt, SAT); chk("sat.FLUSH_COUNT", fcnt, SAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
